// File: rtl/nubus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nubus_pkg
//  Purpose  : Shared types and encodings for the NuBus master sequencer:
//             state enum, completion status codes, null-attention TM code
//             and a counter-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package nubus_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_ATTN = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Completion status, equal to the inverted TM* response of the slave
  localparam logic [1:0] c_STAT_OK    = 2'b00;
  localparam logic [1:0] c_STAT_ERR   = 2'b01;
  localparam logic [1:0] c_STAT_RETRY = 2'b10;
  localparam logic [1:0] c_STAT_TMO   = 2'b11;

  // Transfer mode used for the null-attention cycle (driven inverted on TM*)
  localparam logic [1:0] c_TM_NULL_ATTN = 2'b11;

  // Bits needed to hold 0..max_val, never less than one
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nubus_tmo_counter.sv
`default_nettype none
// ============================================================================
//  Module   : nubus_tmo_counter
//  Purpose  : Saturating DATA-phase timeout counter. o_expired is asserted
//             in the enabled cycle whose increment reaches TMO_CYC.
//  Revision : 1.0  initial release
// ============================================================================
module nubus_tmo_counter
  import nubus_pkg::*;
#(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int             c_W    = cnt_width(TMO_CYC);
  localparam logic [c_W-1:0] c_MAX  = c_W'(TMO_CYC);
  localparam logic [c_W-1:0] c_LAST = c_W'(TMO_CYC - 1);

  logic [c_W-1:0] r_cnt;

  // Count enabled cycles, clear on request, hold at TMO_CYC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != c_MAX)) begin
      r_cnt <= r_cnt + c_W'(1);
    end
  end

  assign o_expired = i_en && (r_cnt >= c_LAST);

endmodule
`default_nettype wire

// File: rtl/nubus_master_seq.sv
`default_nettype none
// ============================================================================
//  Module   : nubus_master_seq
//  Purpose  : NuBus master transaction sequencer: arbitration request,
//             single address cycle, multi-beat data phase with retry and
//             timeout handling, optional null-attention release for locked
//             transactions. All NuBus outputs are Moore outputs of the state.
//  Revision : 1.0  initial release
// ============================================================================
module nubus_master_seq
  import nubus_pkg::*;
#(
  parameter int BLK_W     = 2,
  parameter int TMO_CYC   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic             nub_clkn,
  input  logic             nub_resetn,
  input  logic             mst_req,
  input  logic             mst_lock,
  input  logic [1:0]       mst_tm,
  input  logic [BLK_W-1:0] mst_blk_len,
  input  logic             nub_arb_win,
  input  logic             nub_ackn_i,
  input  logic [1:0]       nub_tmn_i,
  output logic             nub_rqstn_o,
  output logic             nub_startn_o,
  output logic             nub_ackn_o,
  output logic [1:0]       nub_tmn_o,
  output logic             nub_rqstoen_o,
  output logic             nub_startoen_o,
  output logic             drv_tmoen_o,
  output logic             mst_busy,
  output logic             mst_done,
  output logic [1:0]       mst_status,
  output logic [BLK_W:0]   mst_beats
);

  localparam int             c_RW        = cnt_width(MAX_RETRY);
  localparam logic [c_RW-1:0] c_RETRY_MAX = c_RW'(MAX_RETRY);
  localparam logic [BLK_W:0]  c_BEATS_MAX = {1'b1, {BLK_W{1'b0}}};

  state_t            r_state;
  logic              r_lock;
  logic [1:0]        r_tm;
  logic [BLK_W-1:0]  r_blk_len;
  logic [c_RW-1:0]   r_retry;
  logic [BLK_W:0]    r_beats;
  logic [1:0]        r_status;

  state_t            w_state_nxt;
  state_t            w_fin_state;
  logic              w_latch;
  logic [c_RW-1:0]   w_retry_nxt;
  logic [BLK_W:0]    w_beats_nxt;
  logic [1:0]        w_status_nxt;
  logic [1:0]        w_ack_stat;
  logic              w_tmo_en;
  logic              w_tmo_exp;

  // Timeout runs only while waiting for ACK in the data phase
  assign w_tmo_en = (r_state == S_DATA) && nub_ackn_i;

  nubus_tmo_counter #(
    .TMO_CYC (TMO_CYC)
  ) u_tmo (
    .clk       (nub_clkn),
    .rst_n     (nub_resetn),
    .i_clr     (!w_tmo_en),
    .i_en      (w_tmo_en),
    .o_expired (w_tmo_exp)
  );

  assign mst_status = r_status;
  assign mst_beats  = r_beats;
  assign w_ack_stat = ~nub_tmn_i;
  assign w_fin_state = r_lock ? S_ATTN : S_DONE;

  // State, latched request fields and counters
  always_ff @(posedge nub_clkn or negedge nub_resetn) begin
    if (!nub_resetn) begin
      r_state   <= S_IDLE;
      r_lock    <= 1'b0;
      r_tm      <= 2'b00;
      r_blk_len <= '0;
      r_retry   <= '0;
      r_beats   <= '0;
      r_status  <= c_STAT_OK;
    end else begin
      r_state  <= w_state_nxt;
      r_retry  <= w_retry_nxt;
      r_beats  <= w_beats_nxt;
      r_status <= w_status_nxt;
      if (w_latch) begin
        r_lock    <= mst_lock;
        r_tm      <= mst_tm;
        r_blk_len <= mst_blk_len;
      end
    end
  end

  // Next-state, counter updates and NuBus drive values
  always_comb begin
    w_state_nxt    = r_state;
    w_latch        = 1'b0;
    w_retry_nxt    = r_retry;
    w_beats_nxt    = r_beats;
    w_status_nxt   = r_status;
    nub_rqstoen_o  = 1'b1;
    nub_rqstn_o    = 1'b1;
    nub_startoen_o = 1'b1;
    nub_startn_o   = 1'b1;
    drv_tmoen_o    = 1'b1;
    nub_tmn_o      = 2'b11;
    nub_ackn_o     = 1'b1;
    mst_busy       = 1'b1;
    mst_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        mst_busy = 1'b0;
        if (mst_req) begin
          w_latch      = 1'b1;
          w_retry_nxt  = '0;
          w_beats_nxt  = '0;
          w_status_nxt = c_STAT_OK;
          w_state_nxt  = S_ARB;
        end
      end

      S_ARB: begin
        nub_rqstoen_o = 1'b0;
        nub_rqstn_o   = 1'b0;
        if (nub_arb_win) begin
          w_state_nxt = S_ADDR;
        end
      end

      S_ADDR: begin
        nub_startoen_o = 1'b0;
        nub_startn_o   = 1'b0;
        drv_tmoen_o    = 1'b0;
        nub_tmn_o      = ~r_tm;
        nub_ackn_o     = 1'b1;
        // A locked transaction keeps the bus through the data phase
        nub_rqstoen_o  = !r_lock;
        nub_rqstn_o    = !r_lock;
        w_state_nxt    = S_DATA;
      end

      S_DATA: begin
        nub_rqstoen_o = !r_lock;
        nub_rqstn_o   = !r_lock;
        if (!nub_ackn_i) begin
          case (w_ack_stat)
            c_STAT_OK: begin
              if (r_beats < c_BEATS_MAX) begin
                w_beats_nxt = r_beats + (BLK_W + 1)'(1);
              end
              if (r_beats == {1'b0, r_blk_len}) begin
                w_status_nxt = c_STAT_OK;
                w_state_nxt  = w_fin_state;
              end
            end
            c_STAT_RETRY: begin
              if (r_retry < c_RETRY_MAX) begin
                w_retry_nxt = r_retry + c_RW'(1);
                w_beats_nxt = '0;
                w_state_nxt = S_ARB;
              end else begin
                w_status_nxt = c_STAT_RETRY;
                w_state_nxt  = w_fin_state;
              end
            end
            default: begin
              w_status_nxt = w_ack_stat;
              w_state_nxt  = w_fin_state;
            end
          endcase
        end else if (w_tmo_exp) begin
          w_status_nxt = c_STAT_TMO;
          w_state_nxt  = w_fin_state;
        end
      end

      S_ATTN: begin
        nub_startoen_o = 1'b0;
        nub_startn_o   = 1'b0;
        drv_tmoen_o    = 1'b0;
        nub_ackn_o     = 1'b0;
        nub_tmn_o      = ~c_TM_NULL_ATTN;
        w_state_nxt    = S_DONE;
      end

      S_DONE: begin
        mst_done    = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nubus_master_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nubus_master_seq
//  Purpose  : Directed self-checking bench for nubus_master_seq.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nubus_master_seq;

  logic       nub_clkn;
  logic       nub_resetn;
  logic       mst_req;
  logic       mst_lock;
  logic [1:0] mst_tm;
  logic [1:0] mst_blk_len;
  logic       nub_arb_win;
  logic       nub_ackn_i;
  logic [1:0] nub_tmn_i;
  logic       nub_rqstn_o;
  logic       nub_startn_o;
  logic       nub_ackn_o;
  logic [1:0] nub_tmn_o;
  logic       nub_rqstoen_o;
  logic       nub_startoen_o;
  logic       drv_tmoen_o;
  logic       mst_busy;
  logic       mst_done;
  logic [1:0] mst_status;
  logic [2:0] mst_beats;

  int errors = 0;
  int checks = 0;
  int n_addr = 0;
  int n_done = 0;
  int a0;
  int d0;

  nubus_master_seq #(
    .BLK_W     (2),
    .TMO_CYC   (255),
    .MAX_RETRY (3)
  ) dut (
    .nub_clkn       (nub_clkn),
    .nub_resetn     (nub_resetn),
    .mst_req        (mst_req),
    .mst_lock       (mst_lock),
    .mst_tm         (mst_tm),
    .mst_blk_len    (mst_blk_len),
    .nub_arb_win    (nub_arb_win),
    .nub_ackn_i     (nub_ackn_i),
    .nub_tmn_i      (nub_tmn_i),
    .nub_rqstn_o    (nub_rqstn_o),
    .nub_startn_o   (nub_startn_o),
    .nub_ackn_o     (nub_ackn_o),
    .nub_tmn_o      (nub_tmn_o),
    .nub_rqstoen_o  (nub_rqstoen_o),
    .nub_startoen_o (nub_startoen_o),
    .drv_tmoen_o    (drv_tmoen_o),
    .mst_busy       (mst_busy),
    .mst_done       (mst_done),
    .mst_status     (mst_status),
    .mst_beats      (mst_beats)
  );

  // 10 ns clock
  initial nub_clkn = 1'b0;
  always #5 nub_clkn = ~nub_clkn;

  // Count address cycles and done pulses on the falling edge
  always @(negedge nub_clkn) begin
    if (!nub_startoen_o && !nub_startn_o && !drv_tmoen_o && nub_ackn_o) n_addr++;
    if (mst_done) n_done++;
  end

  // Hard stop in case the directed sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge nub_clkn);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic lock, input logic [1:0] tm, input logic [1:0] blk);
    mst_req     = 1'b1;
    mst_lock    = lock;
    mst_tm      = tm;
    mst_blk_len = blk;
  endtask

  initial begin
    mst_req     = 1'b0;
    mst_lock    = 1'b0;
    mst_tm      = 2'b00;
    mst_blk_len = 2'b00;
    nub_arb_win = 1'b0;
    nub_ackn_i  = 1'b1;
    nub_tmn_i   = 2'b11;
    nub_resetn  = 1'b0;
    repeat (2) @(posedge nub_clkn);
    #1;

    // Reset state
    chk("rst_oen", {29'd0, nub_rqstoen_o, nub_startoen_o, drv_tmoen_o}, 32'h7);
    chk("rst_val", {27'd0, nub_rqstn_o, nub_startn_o, nub_ackn_o, nub_tmn_o}, 32'h1F);
    chk("rst_mst", {25'd0, mst_busy, mst_done, mst_status, mst_beats}, 32'h0);
    nub_resetn = 1'b1;
    tick();

    // Single read, win after 2 ARB cycles, ACK on third DATA cycle
    a0 = n_addr; d0 = n_done;
    request(1'b0, 2'b00, 2'b00);
    tick();                                   // ARB
    mst_req = 1'b0;
    chk("t1_arb", {30'd0, nub_rqstoen_o, nub_rqstn_o}, 32'h0);
    chk("t1_busy", {31'd0, mst_busy}, 32'h1);
    tick();                                   // ARB
    tick();                                   // ARB
    nub_arb_win = 1'b1;
    tick();                                   // ADDR
    nub_arb_win = 1'b0;
    chk("t1_addr", {25'd0, nub_startoen_o, nub_startn_o, drv_tmoen_o, nub_ackn_o,
                    nub_tmn_o, nub_rqstoen_o}, 32'h0F);
    tick();                                   // DATA 1
    chk("t1_data_oe", {30'd0, nub_startoen_o, drv_tmoen_o}, 32'h3);
    mst_req = 1'b1;                           // must be ignored while busy
    tick();                                   // DATA 2
    mst_req = 1'b0;
    tick();                                   // DATA 3
    nub_ackn_i = 1'b0; nub_tmn_i = 2'b11;
    tick();                                   // DONE
    nub_ackn_i = 1'b1;
    chk("t1_done", {26'd0, mst_done, mst_status, mst_beats}, {26'd0, 1'b1, 2'b00, 3'd1});
    tick();                                   // IDLE
    chk("t1_idle", {25'd0, mst_busy, mst_done, mst_status, mst_beats}, {25'd0, 2'b00, 2'b00, 3'd1});
    tick();
    chk("t1_no_queue", {31'd0, mst_busy}, 32'h0);
    chk("t1_addr_cnt", n_addr - a0, 32'd1);
    chk("t1_done_cnt", n_done - d0, 32'd1);

    // Four-beat block, all OK
    a0 = n_addr;
    request(1'b0, 2'b10, 2'd3);
    tick();                                   // ARB
    mst_req = 1'b0; nub_arb_win = 1'b1;
    tick();                                   // ADDR
    nub_arb_win = 1'b0;
    chk("t2_addr_tm", {30'd0, nub_tmn_o}, 32'h1);
    tick();                                   // DATA beat 0
    nub_ackn_i = 1'b0; nub_tmn_i = 2'b11;
    tick();                                   // beat 1
    tick();                                   // beat 2
    chk("t2_mid_beats", {29'd0, mst_beats}, 32'd2);
    tick();                                   // beat 3 (final)
    tick();                                   // DONE
    nub_ackn_i = 1'b1;
    chk("t2_done", {26'd0, mst_done, mst_status, mst_beats}, {26'd0, 1'b1, 2'b00, 3'd4});
    chk("t2_addr_cnt", n_addr - a0, 32'd1);
    tick();                                   // IDLE

    // Locked single beat with null-attention
    request(1'b1, 2'b01, 2'd0);
    tick();                                   // ARB
    mst_req = 1'b0; nub_arb_win = 1'b1;
    tick();                                   // ADDR
    nub_arb_win = 1'b0;
    chk("t3_addr", {28'd0, nub_tmn_o, nub_rqstoen_o, nub_rqstn_o}, 32'h8);
    tick();                                   // DATA
    chk("t3_data_rqst", {30'd0, nub_rqstoen_o, nub_rqstn_o}, 32'h0);
    nub_ackn_i = 1'b0; nub_tmn_i = 2'b11;
    tick();                                   // ATTN
    nub_ackn_i = 1'b1;
    chk("t3_attn", {24'd0, nub_startoen_o, nub_startn_o, nub_ackn_o, drv_tmoen_o,
                    nub_tmn_o, nub_rqstoen_o, nub_rqstn_o}, 32'h03);
    chk("t3_attn_nodone", {31'd0, mst_done}, 32'h0);
    tick();                                   // DONE
    chk("t3_done", {26'd0, mst_done, mst_status, mst_beats}, {26'd0, 1'b1, 2'b00, 3'd1});
    tick();                                   // IDLE

    // Try-again-later on every attempt
    a0 = n_addr; d0 = n_done;
    request(1'b0, 2'b00, 2'd0);
    tick();                                   // ARB
    mst_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nub_arb_win = 1'b1;
      tick();                                 // ADDR
      nub_arb_win = 1'b0;
      tick();                                 // DATA
      nub_ackn_i = 1'b0; nub_tmn_i = 2'b01;
      tick();                                 // ARB again or DONE
      nub_ackn_i = 1'b1; nub_tmn_i = 2'b11;
      if (k < 3) chk("t4_rearb", {30'd0, nub_rqstoen_o, mst_done}, 32'h0);
    end
    chk("t4_done", {26'd0, mst_done, mst_status, mst_beats}, {26'd0, 1'b1, 2'b10, 3'd0});
    chk("t4_addr_cnt", n_addr - a0, 32'd4);
    tick();                                   // IDLE

    // Error response on second beat of a two-beat block
    request(1'b0, 2'b00, 2'd1);
    tick();
    mst_req = 1'b0; nub_arb_win = 1'b1;
    tick();                                   // ADDR
    nub_arb_win = 1'b0;
    tick();                                   // DATA beat 0
    nub_ackn_i = 1'b0; nub_tmn_i = 2'b11;
    tick();                                   // beat 1
    nub_tmn_i = 2'b10;
    tick();                                   // DONE
    nub_ackn_i = 1'b1; nub_tmn_i = 2'b11;
    chk("t5_err", {26'd0, mst_done, mst_status, mst_beats}, {26'd0, 1'b1, 2'b01, 3'd1});
    tick();

    // Timeout with no ACK
    request(1'b0, 2'b00, 2'd0);
    tick();
    mst_req = 1'b0; nub_arb_win = 1'b1;
    tick();                                   // ADDR
    nub_arb_win = 1'b0;
    tick();                                   // DATA cycle 1
    repeat (254) tick();                      // DATA cycle 255
    chk("t6_pre", {29'd0, mst_busy, mst_done, nub_startoen_o}, 32'h5);
    tick();
    chk("t6_tmo", {26'd0, mst_done, mst_status, mst_beats}, {26'd0, 1'b1, 2'b11, 3'd0});
    tick();

    // ACK on the expiry cycle wins over timeout
    request(1'b0, 2'b00, 2'd0);
    tick();
    mst_req = 1'b0; nub_arb_win = 1'b1;
    tick();
    nub_arb_win = 1'b0;
    tick();                                   // DATA cycle 1
    repeat (254) tick();                      // DATA cycle 255
    nub_ackn_i = 1'b0; nub_tmn_i = 2'b11;
    tick();
    nub_ackn_i = 1'b1;
    chk("t7_ack_prio", {26'd0, mst_done, mst_status, mst_beats}, {26'd0, 1'b1, 2'b00, 3'd1});
    tick();

    // Reset in the middle of a locked data phase
    d0 = n_done;
    request(1'b1, 2'b00, 2'd1);
    tick();
    mst_req = 1'b0; nub_arb_win = 1'b1;
    tick();
    nub_arb_win = 1'b0;
    tick();                                   // DATA beat 0
    nub_ackn_i = 1'b0; nub_tmn_i = 2'b11;
    tick();                                   // DATA beat 1
    nub_ackn_i = 1'b1;
    chk("t8_pre", {28'd0, nub_rqstoen_o, mst_beats}, {28'd0, 1'b0, 3'd1});
    #1;
    nub_resetn = 1'b0;
    #1;
    chk("t8_oen", {29'd0, nub_rqstoen_o, nub_startoen_o, drv_tmoen_o}, 32'h7);
    chk("t8_mst", {25'd0, mst_busy, mst_done, mst_status, mst_beats}, 32'h0);
    tick();
    nub_resetn = 1'b1;
    tick();
    tick();
    tick();
    chk("t8_no_done", n_done - d0, 32'd0);
    chk("t8_idle", {31'd0, mst_busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nubus_master_seq.md
NUBUS_MASTER_SEQ -- requirements
Module: nubus_master_seq

Interface
REQ-001 SHALL have parameter BLK_W, default 2, meaning block-length field width; max beats per transaction = 2**BLK_W.
REQ-002 SHALL have parameter TMO_CYC, default 255, meaning DATA-phase cycles without ACK before timeout.
REQ-003 SHALL have parameter MAX_RETRY, default 3, meaning try-again-later retries before error completion.
REQ-004 SHALL have port nub_clkn, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port nub_resetn, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port mst_req, input, 1, meaning transaction request, sampled in IDLE only.
REQ-007 SHALL have ports mst_lock (input, 1, locked transaction), mst_tm (input, 2, transfer mode for address cycle) and mst_blk_len (input, BLK_W, beats minus one).
REQ-008 SHALL have port nub_arb_win, input, 1, meaning arbitration won and bus idle.
REQ-009 SHALL have ports nub_ackn_i (input, 1) and nub_tmn_i (input, 2), meaning slave ACK* and TM* response.
REQ-010 SHALL have ports nub_rqstn_o, nub_startn_o, nub_ackn_o (output, 1 each) and nub_tmn_o (output, 2), meaning NuBus values, active-low.
REQ-011 SHALL have ports nub_rqstoen_o, nub_startoen_o, drv_tmoen_o (output, 1 each), meaning active-low output enables; drv_tmoen_o covers TM* and ACK*.
REQ-012 SHALL have ports mst_busy (output, 1), mst_done (output, 1, one-cycle pulse), mst_status (output, 2) and mst_beats (output, BLK_W+1, completed beats).

Function
REQ-013 SHALL implement states IDLE, ARB, ADDR, DATA, ATTN, DONE.
REQ-014 IDLE: mst_req=1 -> latch lock/tm/blk_len, clear retry and beat counters, go ARB; mst_busy=1 in every state except IDLE.
REQ-015 ARB: nub_rqstoen_o=0, nub_rqstn_o=0; nub_arb_win=1 -> ADDR next cycle.
REQ-016 ADDR: exactly one cycle; nub_startoen_o=0, nub_startn_o=0, drv_tmoen_o=0, nub_tmn_o=~tm, nub_ackn_o=1; RQST* released unless locked; -> DATA.
REQ-017 DATA: START* released, TM*/ACK* enables off; timeout counter increments each cycle with nub_ackn_i=1.
REQ-018 On nub_ackn_i=0 in DATA, status = ~nub_tmn_i: 00 = OK, 01 = error, 10 = try-again-later, 11 = timeout-encoded error.
REQ-019 Status OK and beats < blk_len+1 -> increment mst_beats, clear timeout counter, stay DATA.
REQ-020 Status OK on final beat, or error -> ATTN if locked, else DONE.
REQ-021 Try-again-later with retry count < MAX_RETRY -> increment retry count, clear mst_beats, go ARB; at MAX_RETRY -> complete with status 10.
REQ-022 Timeout counter reaching TMO_CYC -> status 11, ATTN if locked else DONE; ACK in the same cycle takes priority over timeout.
REQ-023 ATTN: one cycle null-attention: START* and ACK* driven 0, TM* driven 00 (TM=11), RQST* released; -> DONE.
REQ-024 DONE: mst_done=1 for one cycle; mst_status/mst_beats hold until next accepted request; -> IDLE.
REQ-025 mst_req while busy SHALL be ignored, not queued.
REQ-026 All counters saturate; none wrap.

Reset
REQ-027 nub_resetn=0 SHALL immediately force IDLE, all *_oen_o=1, all NuBus value outputs=1, mst_busy=0, mst_done=0, mst_status=00, mst_beats=0, counters=0.
REQ-028 Reset mid-transaction SHALL abort without a DONE pulse or ATTN cycle.

Structure
REQ-029 nubus_pkg SHALL hold the state enum, TM/status encodings (OK, ERR, RETRY, TMO) and null-attention TM constant.
REQ-030 Timeout counting SHALL be a sub-module nubus_tmo_counter (clear, enable, expired output, parameter TMO_CYC).

Verification
REQ-031 Single read, tm=00, blk_len=0, win after 2 cycles, ACK with TM*=11 after 3 cycles -> one START* pulse, mst_done with status 00, mst_beats=1.
REQ-032 Block, blk_len=3, four ACKs OK -> mst_beats=4, status 00, exactly one START*.
REQ-033 Locked, one beat -> RQST* held through DATA, ATTN cycle with START*=0, ACK*=0, TM*=00, then DONE.
REQ-034 Try-again-later on every attempt, MAX_RETRY=3 -> 4 address cycles, final status 10.
REQ-035 No ACK, TMO_CYC=255 -> status 11 on cycle 255 of DATA; ACK on the expiry cycle -> status from TM*.
REQ-036 nub_resetn low during DATA -> all enables high in same cycle, no mst_done pulse.
